// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg
// Shared types and constants for the AXI memory arbiter:
//   state_e  - transaction sequencer states
//   owner_e  - which requester owns the current transaction
//   AXI encodings and the per-requester AXI IDs.
package axi_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] IF_ID          = 4'h0;
    localparam logic [3:0] D_ID           = 4'h1;

endpackage

// File: rtl/axi_mem_arbiter_pick.sv
// axi_arb_pick
// Combinational grant choice between the fetch and data requesters.
//   if_req_i      - fetch request
//   d_req_i       - data request
//   last_owner_i  - most recent grant (present only with AXI_ARB_RR_EN)
//   valid_o       - at least one requester is asking
//   owner_o       - chosen requester
// Build option AXI_ARB_RR_EN: round-robin on contention; otherwise data
// always wins over fetch.
module axi_arb_pick
    import axi_arb_pkg::*;
(
    input  logic   if_req_i,
    input  logic   d_req_i,
`ifdef AXI_ARB_RR_EN
    input  owner_e last_owner_i,
`endif
    output logic   valid_o,
    output owner_e owner_o
);

    always_comb begin
        valid_o = if_req_i | d_req_i;
        owner_o = OWN_D;
`ifdef AXI_ARB_RR_EN
        if (if_req_i && d_req_i) begin
            // Contention: hand the bus to whoever did not have it last.
            owner_o = (last_owner_i == OWN_D) ? OWN_IF : OWN_D;
        end else if (if_req_i) begin
            owner_o = OWN_IF;
        end
`else
        if (!d_req_i) begin
            owner_o = OWN_IF;
        end
`endif
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter
// Shares one 64-bit AXI master port between instruction fetch (read only)
// and the data requester (read/write). One single-beat transaction is in
// flight at a time: AR/R for reads, AW+W/B for writes.
// Ports:
//   clk_i, rst_ni                - clock, asynchronous active-low reset
//   if_req_i/if_addr_i/if_size_i - fetch request; if_gnt_o accept pulse,
//   if_done_o/if_rdata_o/if_err_o  completion pulse, held data, error
//   d_*                          - same for data, plus d_we_i/d_wdata_i/d_wstrb_i
//   axi_aw*/axi_w*/axi_b*/axi_ar*/axi_r* - AXI4 master channels
// Build option AXI_ARB_RR_EN selects round-robin arbitration (see axi_arb_pick).
module axi_mem_arbiter
    import axi_arb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    // fetch requester
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic [2:0]  if_size_i,
    output logic        if_gnt_o,
    output logic        if_done_o,
    output logic [63:0] if_rdata_o,
    output logic        if_err_o,
    // data requester
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [2:0]  d_size_i,
    input  logic [63:0] d_wdata_i,
    input  logic [7:0]  d_wstrb_i,
    output logic        d_gnt_o,
    output logic        d_done_o,
    output logic [63:0] d_rdata_o,
    output logic        d_err_o,
    // AXI write address
    output logic [3:0]  axi_awid_o,
    output logic [31:0] axi_awaddr_o,
    output logic [7:0]  axi_awlen_o,
    output logic [2:0]  axi_awsize_o,
    output logic [1:0]  axi_awburst_o,
    output logic        axi_awvalid_o,
    input  logic        axi_awready_i,
    // AXI write data
    output logic [63:0] axi_wdata_o,
    output logic [7:0]  axi_wstrb_o,
    output logic        axi_wlast_o,
    output logic        axi_wvalid_o,
    input  logic        axi_wready_i,
    // AXI write response
    input  logic [3:0]  axi_bid_i,
    input  logic [1:0]  axi_bresp_i,
    input  logic        axi_bvalid_i,
    output logic        axi_bready_o,
    // AXI read address
    output logic [3:0]  axi_arid_o,
    output logic [31:0] axi_araddr_o,
    output logic [7:0]  axi_arlen_o,
    output logic [2:0]  axi_arsize_o,
    output logic [1:0]  axi_arburst_o,
    output logic        axi_arvalid_o,
    input  logic        axi_arready_i,
    // AXI read data
    input  logic [3:0]  axi_rid_i,
    input  logic [63:0] axi_rdata_i,
    input  logic [1:0]  axi_rresp_i,
    input  logic        axi_rlast_i,
    input  logic        axi_rvalid_i,
    output logic        axi_rready_o
);

    state_e      state_q;
    owner_e      owner_q;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic [3:0]  id_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic        aw_done_q, w_done_q;
    logic        if_done_q, d_done_q, if_err_q, d_err_q;
    logic [63:0] if_rdata_q, d_rdata_q;

    logic        pick_valid;
    owner_e      pick_owner;
    logic        grant;
    logic        start_write;
    logic        aw_hs, w_hs;

    // Only one transaction is ever outstanding, so IDs and rlast carry
    // no information for us.
    logic        unused_axi;
    assign unused_axi = ^{axi_rid_i, axi_bid_i, axi_rlast_i};

`ifdef AXI_ARB_RR_EN
    owner_e last_owner_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_owner_q <= OWN_IF;
        end else if (grant) begin
            last_owner_q <= pick_owner;
        end
    end
`endif

    axi_arb_pick u_pick (
        .if_req_i     (if_req_i),
        .d_req_i      (d_req_i),
`ifdef AXI_ARB_RR_EN
        .last_owner_i (last_owner_q),
`endif
        .valid_o      (pick_valid),
        .owner_o      (pick_owner)
    );

    // Grant is combinational in IDLE; qualified with reset so no accept
    // pulse can leak out while the block is held in reset.
    assign grant       = rst_ni && (state_q == S_IDLE) && pick_valid;
    assign if_gnt_o    = grant && (pick_owner == OWN_IF);
    assign d_gnt_o     = grant && (pick_owner == OWN_D);
    assign start_write = (pick_owner == OWN_D) && d_we_i;

    assign aw_hs = axi_awvalid_o && axi_awready_i;
    assign w_hs  = axi_wvalid_o && axi_wready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            size_q     <= '0;
            id_q       <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_err_q   <= 1'b0;
            d_err_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        owner_q <= pick_owner;
                        if (pick_owner == OWN_D) begin
                            id_q    <= D_ID;
                            addr_q  <= d_addr_i;
                            size_q  <= d_size_i;
                            wdata_q <= d_wdata_i;
                            wstrb_q <= d_wstrb_i;
                        end else begin
                            id_q    <= IF_ID;
                            addr_q  <= if_addr_i;
                            size_q  <= if_size_i;
                        end
                        if (start_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= S_WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_ADDR;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (axi_arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (axi_rvalid_i) begin
                        rready_q <= 1'b0;
                        if (owner_q == OWN_D) begin
                            d_rdata_q <= axi_rdata_i;
                            d_err_q   <= (axi_rresp_i != AXI_RESP_OKAY);
                            d_done_q  <= 1'b1;
                        end else begin
                            if_rdata_q <= axi_rdata_i;
                            if_err_q   <= (axi_rresp_i != AXI_RESP_OKAY);
                            if_done_q  <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                end
                S_WR_REQ: begin
                    // AW and W complete independently; either may finish first
                    // or both in the same cycle.
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (axi_bvalid_i) begin
                        bready_q <= 1'b0;
                        d_err_q  <= (axi_bresp_i != AXI_RESP_OKAY);
                        d_done_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign if_done_o     = if_done_q;
    assign if_rdata_o    = if_rdata_q;
    assign if_err_o      = if_err_q;
    assign d_done_o      = d_done_q;
    assign d_rdata_o     = d_rdata_q;
    assign d_err_o       = d_err_q;

    assign axi_awid_o    = id_q;
    assign axi_awaddr_o  = addr_q;
    assign axi_awlen_o   = 8'd0;
    assign axi_awsize_o  = size_q;
    assign axi_awburst_o = AXI_BURST_INCR;
    assign axi_awvalid_o = awvalid_q;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = wstrb_q;
    assign axi_wlast_o   = 1'b1;
    assign axi_wvalid_o  = wvalid_q;
    assign axi_bready_o  = bready_q;

    assign axi_arid_o    = id_q;
    assign axi_araddr_o  = addr_q;
    assign axi_arlen_o   = 8'd0;
    assign axi_arsize_o  = size_q;
    assign axi_arburst_o = AXI_BURST_INCR;
    assign axi_arvalid_o = arvalid_q;
    assign axi_rready_o  = rready_q;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
module tb_axi_mem_arbiter;

    logic        clk, rst_n;
    logic        if_req;  logic [31:0] if_addr; logic [2:0] if_size;
    logic        if_gnt, if_done, if_err;   logic [63:0] if_rdata;
    logic        d_req, d_we; logic [31:0] d_addr; logic [2:0] d_size;
    logic [63:0] d_wdata; logic [7:0] d_wstrb;
    logic        d_gnt, d_done, d_err;      logic [63:0] d_rdata;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [63:0] wdata, rdata;

    axi_mem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_size_i(if_size),
        .if_gnt_o(if_gnt), .if_done_o(if_done), .if_rdata_o(if_rdata), .if_err_o(if_err),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_size_i(d_size),
        .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb),
        .d_gnt_o(d_gnt), .d_done_o(d_done), .d_rdata_o(d_rdata), .d_err_o(d_err),
        .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen), .axi_awsize_o(awsize),
        .axi_awburst_o(awburst), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
        .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
        .axi_wvalid_o(wvalid), .axi_wready_i(wready),
        .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
        .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
        .axi_arburst_o(arburst), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
        .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
        .axi_rvalid_i(rvalid), .axi_rready_o(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          owner;   // 1 = data
        bit          is_write;
        logic [63:0] data;
        bit          err;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (if_done || d_done) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_done", {62'd0, d_done, if_done}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_owner", {63'd0, d_done}, {63'd0, mon_e.owner});
                if (mon_e.owner) begin
                    if (!mon_e.is_write) chk("sb_d_rdata", d_rdata, mon_e.data);
                    chk("sb_d_err", {63'd0, d_err}, {63'd0, mon_e.err});
                end else begin
                    chk("sb_if_rdata", if_rdata, mon_e.data);
                    chk("sb_if_err", {63'd0, if_err}, {63'd0, mon_e.err});
                end
                $display("done: owner=%0d rdata=%h err=%0d", d_done,
                         d_done ? d_rdata : if_rdata, d_done ? d_err : if_err);
            end
        end
    end

    // ---------------- AXI slave model (drives on negedge) ----------------
    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [63:0] s_rdata = '0;
    logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;

    initial begin
        int rs, rc, ws, awc, wc, bc;
        bit aw_hs, w_hs;
        rs = 0; ws = 0; rc = 0; awc = 0; wc = 0; bc = 0; aw_hs = 0; w_hs = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = 0; rid = 0; rlast = 1;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rs = 0; ws = 0;
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            end else begin
                case (rs)
                    0: if (arvalid) begin
                        rc = ar_delay;
                        if (rc == 0) begin arready = 1; rs = 2; end else rs = 1;
                    end
                    1: begin
                        rc--;
                        if (rc == 0) begin arready = 1; rs = 2; end
                    end
                    2: begin
                        arready = 0; rc = r_delay;
                        if (rc == 0) begin rvalid = 1; rdata = s_rdata; rresp = s_rresp; rs = 4; end
                        else rs = 3;
                    end
                    3: begin
                        rc--;
                        if (rc == 0) begin rvalid = 1; rdata = s_rdata; rresp = s_rresp; rs = 4; end
                    end
                    default: begin rvalid = 0; rs = 0; end
                endcase
                if (ws == 0 && awvalid) begin
                    awc = aw_delay; wc = w_delay; aw_hs = 0; w_hs = 0; ws = 1;
                end
                if (ws == 1) begin
                    if (awready) begin awready = 0; aw_hs = 1; end
                    else if (!aw_hs) begin if (awc == 0) awready = 1; else awc--; end
                    if (wready) begin wready = 0; w_hs = 1; end
                    else if (!w_hs) begin if (wc == 0) wready = 1; else wc--; end
                    if (aw_hs && w_hs) begin
                        bc = b_delay;
                        if (bc == 0) begin bvalid = 1; bresp = s_bresp; ws = 3; end else ws = 2;
                    end
                end else if (ws == 2) begin
                    bc--;
                    if (bc == 0) begin bvalid = 1; bresp = s_bresp; ws = 3; end
                end else if (ws == 3) begin
                    bvalid = 0; ws = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit bench_last;   // most recent grant, 1 = data

    function automatic bit exp_win(input bit last);
`ifdef AXI_ARB_RR_EN
        return !last;
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input bit owner, input bit is_write, input logic [63:0] data, input bit err);
        exp_t e;
        e.owner = owner; e.is_write = is_write; e.data = data; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input bit who, input string nm);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(who ? d_done : if_done) && n < 200);
        chk(nm, {63'd0, (who ? d_done : if_done)}, 64'd1);
    endtask

    task automatic do_read(input bit who, input logic [31:0] addr, input logic [63:0] data, input bit err);
        tick();
        s_rdata = data;
        if (who) begin d_req = 1; d_we = 0; d_addr = addr; d_size = 3; end
        else     begin if_req = 1; if_addr = addr; if_size = 3; end
        #1;
        chk("rd_gnt", {62'd0, d_gnt, if_gnt}, who ? 64'd2 : 64'd1);
        push(who, 0, data, err);
        bench_last = who;
        $display("read: owner=%0d addr=%h", who, addr);
        tick();
        if_req = 0; d_req = 0;
        wait_done(who, "rd_done_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit win, stall_ok;
        rst_n = 0; if_req = 1; if_addr = 32'h1234_5678; if_size = 3;
        d_req = 0; d_we = 0; d_addr = 0; d_size = 3; d_wdata = 0; d_wstrb = 0;
        bench_last = 0;
        repeat (3) tick();
        // reset state; gnt must stay low while held in reset
        chk("rst_gnt", {62'd0, d_gnt, if_gnt}, 64'd0);
        chk("rst_valids", {59'd0, arvalid, rready, awvalid, wvalid, bready}, 64'd0);
        chk("rst_done", {62'd0, d_done, if_done}, 64'd0);
        chk("rst_rdata", if_rdata | d_rdata, 64'd0);
        chk("rst_err", {62'd0, d_err, if_err}, 64'd0);
        chk("rst_addr", {32'd0, araddr}, 64'd0);
        if_req = 0;
        tick();
        rst_n = 1;
        tick();

        // T1: fetch read, zero-wait slave, cycle-accurate
        s_rdata = 64'h0000_0013_0000_0093;
        if_req = 1; if_addr = 32'h8000_0000; if_size = 3;
        #1;
        chk("t1_gnt_c0", {62'd0, d_gnt, if_gnt}, 64'd1);
        push(0, 0, 64'h0000_0013_0000_0093, 0);
        bench_last = 0;
        tick(); if_req = 0;
        chk("t1_arvalid_c1", {63'd0, arvalid}, 64'd1);
        chk("t1_arid", {60'd0, arid}, 64'd0);
        chk("t1_araddr", {32'd0, araddr}, 64'h8000_0000);
        chk("t1_ar_fields", {51'd0, arlen, arsize, arburst}, {51'd0, 8'd0, 3'd3, 2'b01});
        tick();
        chk("t1_rready_c2", {62'd0, rready, arvalid}, 64'd2);
        tick();
        chk("t1_done_c3", {63'd0, if_done}, 64'd1);

        // T2: data write, awready 3 cycles late, wready immediate
        tick();
        aw_delay = 3; w_delay = 0;
        d_req = 1; d_we = 1; d_addr = 32'h8000_1000; d_size = 3;
        d_wdata = 64'hDEAD_BEEF_CAFE_F00D; d_wstrb = 8'hFF;
        #1;
        chk("t2_gnt", {62'd0, d_gnt, if_gnt}, 64'd2);
        push(1, 1, 64'd0, 0);
        bench_last = 1;
        $display("write: addr=%h data=%h", d_addr, d_wdata);
        tick(); d_req = 0; d_we = 0; d_wdata = 0;
        chk("t2_valids_c1", {62'd0, awvalid, wvalid}, 64'd3);
        chk("t2_awid", {60'd0, awid}, 64'd1);
        chk("t2_awaddr", {32'd0, awaddr}, 64'h8000_1000);
        chk("t2_wdata", wdata, 64'hDEAD_BEEF_CAFE_F00D);
        chk("t2_w_fields", {46'd0, wstrb, wlast, awlen, awburst}, {46'd0, 8'hFF, 1'b1, 8'd0, 2'b01});
        tick();
        chk("t2_valids_c2", {62'd0, awvalid, wvalid}, 64'd2);
        tick(); tick();
        chk("t2_valids_c4", {62'd0, awvalid, wvalid}, 64'd2);
        tick();
        chk("t2_valids_c5", {62'd0, awvalid, wvalid}, 64'd0);
        wait_done(1, "t2_done_timeout");
        aw_delay = 0;

        // T3: simultaneous requests; loser granted in the winner's done cycle
        tick();
        win = exp_win(bench_last);
        s_rdata = 64'h0000_0000_AAAA_0001;
        if_req = 1; if_addr = 32'h8000_0100;
        d_req = 1; d_we = 0; d_addr = 32'h8000_2000;
        #1;
        chk("t3_first_gnt", {62'd0, d_gnt, if_gnt}, win ? 64'd2 : 64'd1);
        push(win, 0, 64'h0000_0000_AAAA_0001, 0);
        bench_last = win;
        tick();
        if (win) d_req = 0; else if_req = 0;
        wait_done(win, "t3_first_done");
        chk("t3_second_gnt", {62'd0, d_gnt, if_gnt}, win ? 64'd1 : 64'd2);
        s_rdata = 64'h0000_0000_BBBB_0002;
        push(!win, 0, 64'h0000_0000_BBBB_0002, 0);
        bench_last = !win;
        tick();
        if_req = 0; d_req = 0;
        wait_done(!win, "t3_second_done");

        // T4: four back-to-back contended rounds
        tick();
        if_req = 1; d_req = 1; d_we = 0;
        #1;
        for (int r = 0; r < 4; r++) begin
            win = exp_win(bench_last);
            s_rdata = 64'h0000_0000_C0DE_0000 + 64'(r);
            chk("t4_round_gnt", {62'd0, d_gnt, if_gnt}, win ? 64'd2 : 64'd1);
            push(win, 0, 64'h0000_0000_C0DE_0000 + 64'(r), 0);
            bench_last = win;
            wait_done(win, "t4_round_done");
            if (r == 3) begin if_req = 0; d_req = 0; end
        end

        // T5: error response, then clean response
        s_rresp = 2'b10;
        do_read(0, 32'h8000_0200, 64'h0000_0000_0000_0BAD, 1);
        s_rresp = 2'b00;
        do_read(0, 32'h8000_0208, 64'h0000_0000_0000_0600, 0);
        do_read(1, 32'h8000_3000, 64'h0123_4567_89AB_CDEF, 0);

        // T6: rvalid stalled 20 cycles; data request waits without a grant
        tick();
        r_delay = 20; s_rdata = 64'h5555_AAAA_5555_AAAA;
        if_req = 1; if_addr = 32'h8000_0300;
        #1;
        chk("t6_gnt", {62'd0, d_gnt, if_gnt}, 64'd1);
        push(0, 0, 64'h5555_AAAA_5555_AAAA, 0);
        tick(); if_req = 0;
        d_req = 1; d_we = 0; d_addr = 32'h8000_4000;
        stall_ok = 1;
        for (int i = 0; i < 21; i++) begin
            tick();
            if (!(rready && !arvalid && !if_done && !d_done && !d_gnt && !if_gnt)) stall_ok = 0;
        end
        chk("t6_stall_stable", {63'd0, stall_ok}, 64'd1);
        tick();
        chk("t6_done_after_stall", {63'd0, if_done}, 64'd1);
        chk("t6_d_gnt_in_done_cycle", {62'd0, d_gnt, if_gnt}, 64'd2);
        r_delay = 0; s_rdata = 64'h0000_0000_0000_4444;
        push(1, 0, 64'h0000_0000_0000_4444, 0);
        tick(); d_req = 0;
        wait_done(1, "t6_d_done");

        // T7: reset while in RD_DATA with rvalid pending
        tick();
        r_delay = 3; s_rdata = 64'hFFFF_0000_FFFF_0000;
        if_req = 1; if_addr = 32'h8000_0400;
        #1;
        chk("t7_gnt", {62'd0, d_gnt, if_gnt}, 64'd1);
        push(0, 0, 64'hFFFF_0000_FFFF_0000, 0);
        tick(); if_req = 0;
        repeat (4) tick();
        chk("t7_pending", {62'd0, rready, rvalid}, 64'd3);
        rst_n = 0;
        #1;
        exp_q.delete();
        chk("t7_rst_valids", {61'd0, arvalid, rready, awvalid}, 64'd0);
        chk("t7_rst_done", {62'd0, d_done, if_done}, 64'd0);
        chk("t7_rst_rdata", if_rdata, 64'd0);
        repeat (2) tick();
        rst_n = 1;
        r_delay = 0;
        bench_last = 0;
        do_read(0, 32'h8000_0500, 64'h0000_0000_7777_0001, 0);

        repeat (3) tick();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_mem_arbiter.md
# axi_mem_arbiter

Shares the core's single 64-bit AXI master port between the instruction-fetch requester and the data-memory requester. Each requester gets a simple req/gnt/done interface. The block sequences one single-beat AXI transaction at a time: AR/R for reads, AW+W/B for writes. It sits between the core's fetch and LSU units and the top-level AXI pins.

## Interface
- IF_ID, 4'h0, AXI ID driven on fetch transactions
- D_ID, 4'h1, AXI ID driven on data transactions
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  32  fetch address
- if_size  in  3  AXI size encoding (3 = 8 bytes)
- if_gnt  out  1  one-cycle accept pulse
- if_done  out  1  one-cycle pulse; if_rdata/if_err valid
- if_rdata  out  64  read data, held until next if_done
- if_err  out  1  response was not OKAY
- d_req, d_we  in  1 each  data request; 1 = write
- d_addr  in  32  / d_size  in  3  / d_wdata  in  64  / d_wstrb  in  8
- d_gnt  out  1  / d_done  out  1  / d_rdata  out  64  / d_err  out  1  same semantics as fetch
- axi_aw{id,addr,len,size,burst,valid}  out  4/32/8/3/2/1;  axi_awready  in  1
- axi_w{data,strb,last,valid}  out  64/8/1/1;  axi_wready  in  1
- axi_b{id,resp,valid}  in  4/2/1;  axi_bready  out  1
- axi_ar{id,addr,len,size,burst,valid}  out  4/32/8/3/2/1;  axi_arready  in  1
- axi_r{id,data,resp,last,valid}  in  4/64/2/1/1;  axi_rready  out  1

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- In IDLE, pick one requester:
  - if_gnt/d_gnt is asserted combinationally in the same cycle.
  - Latch addr, size, we, wdata, wstrb and the owner in that cycle.
  - Go to RD_ADDR, or to WR_REQ if the data requester is writing.
- Arbitration default is fixed priority: data beats fetch when both request.
- All AXI outputs come from registers.
  - awlen/arlen = 0, burst = 2'b01 (INCR), wlast = 1.
  - arid/awid = owner's ID parameter.
- RD_ADDR: arvalid = 1 until arready, then go to RD_DATA.
- RD_DATA: rready = 1. On rvalid:
  - Capture rdata into the owner's rdata register.
  - Owner's err = (rresp != 2'b00).
  - Pulse the owner's done next cycle; return to IDLE.
- WR_REQ: awvalid and wvalid rise together and drop independently on their own handshakes.
  - Track aw_done and w_done.
  - When both are complete, including the same cycle, go to WR_RESP.
- WR_RESP: bready = 1. On bvalid: d_err = (bresp != 2'b00), pulse d_done, return to IDLE.
- rid, bid and rlast are ignored; only one transaction is ever outstanding.
- Requesters may change inputs freely after gnt. Each may re-request immediately after its done.

## Timing
- Reset values:
  - All valid/ready outputs, gnt and done are 0; state IDLE.
  - rdata = 0, err = 0, address and data registers = 0.
- Read latency: req at cycle 0 (gnt at 0) → arvalid at cycle 1 → done = 1 cycle after the R handshake.
  - Zero-wait slave: done at cycle 3.
- Write latency: gnt at 0 → aw/wvalid at 1 → done 1 cycle after the B handshake.
  - Zero-wait slave: done at cycle 3.
- done is registered. The IDLE state coincides with the done cycle, so a new grant can occur in the same cycle as done.
- Stalled slave: valids and payload stay stable until handshake (AXI rule). No timeout.
- Reset asserted mid-transaction:
  - Immediate asynchronous return to IDLE; all valids drop; the pending transaction is abandoned with no done.
  - The slave shares this reset.
- gnt is never asserted outside IDLE; a requester raising req mid-transaction waits.

## Configuration
- AXI_ARB_RR_EN defined:
  - Round-robin arbitration. A last_owner register (reset = fetch) records the most recent grant.
  - On a simultaneous request, grant the requester that was not last_owner.
  - A single requester is always granted.
- Undefined: fixed data-over-fetch priority; no last_owner register.

## Structure
- Package axi_arb_pkg holds:
  - State enum.
  - AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00.
  - Owner encoding (OWN_IF, OWN_D).
- Sub-module axi_arb_pick:
  - Combinational grant choice from the two req bits plus last_owner.
  - Contains the AXI_ARB_RR_EN conditional.

## Test plan
- Fetch read at 0x8000_0000, zero-wait slave, rdata 0x0000_0013_0000_0093:
  - if_gnt at cycle 0, arvalid at 1 with arid 0, if_done at 3, if_rdata matches, if_err = 0.
- Data write 0x8000_1000, wdata 0xDEAD_BEEF_CAFE_F00D, wstrb 0xFF:
  - awready delayed 3 cycles, wready immediate; wvalid drops after 1 cycle, awvalid after 4.
  - Single B; d_done, d_err = 0.
- Both request in the same cycle:
  - Fixed priority: d_gnt first, then if_gnt after d_done.
  - With AXI_ARB_RR_EN: alternating grants over 4 back-to-back rounds.
- Read returns rresp = 2'b10 → owner's err = 1 with done; next transaction reports err = 0.
- Reset driven low while in RD_DATA with rvalid pending → arvalid, rready and the done outputs are 0 immediately; after release, a new fetch completes normally.
- rvalid stalled 20 cycles → rready stays high, no done until the handshake, arvalid never reasserted.
